// File: rtl/sram_stream_pkg.sv
// Shared types for the SRAM FIFO drain path: controller state encoding and skid depth.
package sram_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;

  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry register FIFO that absorbs the one-cycle read latency of the upstream SRAM FIFO.
// Head always lives in slot0 so the output is a plain register.
module skid_fifo2
  import sram_stream_pkg::*;
#(
  parameter int BITS = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push_i,
  input  logic [BITS-1:0] push_data_i,
  input  logic            pop_i,
  output logic [1:0]      occ_o,
  output logic [BITS-1:0] head_o
);

  logic [1:0]      occ_q, occ_d;
  logic [BITS-1:0] slot0_q, slot0_d;
  logic [BITS-1:0] slot1_q, slot1_d;
  logic            pop_ok, push_ok;

  always_comb begin
    pop_ok  = pop_i && (occ_q != 2'd0);
    push_ok = push_i && ((occ_q != 2'(SKID_DEPTH)) || pop_ok);
    occ_d   = occ_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    // NOTE: blocking assignments in combinational logic let the push step see the post-pop occupancy.
    if (pop_ok) begin
      slot0_d = slot1_q;
      occ_d   = occ_q - 2'd1;
    end
    if (push_ok) begin
      if (occ_d == 2'd0) slot0_d = push_data_i;
      else               slot1_d = push_data_i;
      occ_d = occ_d + 2'd1;
    end
  end

  // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q   <= 2'd0;
      // NOTE: the data slots are reset too, so the output word reads zero straight after reset.
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      occ_q   <= occ_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

  assign occ_o  = occ_q;
  assign head_o = slot0_q;

endmodule

// File: rtl/sram_drain_ctrl.sv
// Drains the mySRAM word FIFO into a valid/ready stream with burst framing,
// a running accepted-word count and a sticky overflow flag.
module sram_drain_ctrl
  import sram_stream_pkg::*;
#(
  parameter int BITS      = 12,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             fifo_ready,
  input  logic             fifo_overflow,
  input  logic [BITS-1:0]  fifo_data,
  output logic             fifo_read,
  output logic             m_valid,
  output logic [BITS-1:0]  m_data,
  output logic             m_last,
  input  logic             m_ready,
  input  logic             ovf_clr,
  output logic             ovf_sticky,
  output logic             busy,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int CW     = BEAT_W + 2;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  state_e            state_q;
  logic              inflight_q;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic              ovf_q, ovf_d;

  logic [1:0]        occ;
  logic [BITS-1:0]   head;
  logic              pop, last_beat, wrap;
  logic              credit_ok, wind_ok;
  logic [CW-1:0]     committed, words_left;

  skid_fifo2 #(.BITS(BITS)) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (inflight_q),
    .push_data_i (fifo_data),
    .pop_i       (pop),
    .occ_o       (occ),
    .head_o      (head)
  );

  assign m_valid   = (occ != 2'd0);
  assign m_data    = head;
  assign pop       = m_valid & m_ready;
  assign last_beat = (beat_q == LAST_BEAT);
  assign m_last    = m_valid & last_beat;
  assign wrap      = pop & last_beat;

  always_comb begin
    // Words already owed to the skid: stored plus the one arriving from the FIFO.
    committed  = CW'(occ) + CW'(inflight_q);
    words_left = CW'(BURST_LEN) - CW'(beat_q);
    credit_ok  = committed < (CW'(2) + CW'(pop));
    // With en low, only fetch what is still needed to close the current burst.
    wind_ok    = (beat_q != '0) && (committed < words_left);
    fifo_read  = rst_n & fifo_ready & (state_q != IDLE) & credit_ok & (en | wind_ok);

    beat_d = beat_q;
    if (pop) beat_d = last_beat ? '0 : beat_q + BEAT_W'(1);
    word_cnt_d = word_cnt_q + CNT_W'(pop);
    ovf_d      = fifo_overflow | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      inflight_q <= 1'b0;
      beat_q     <= '0;
      word_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      inflight_q <= fifo_read;
      beat_q     <= beat_d;
      word_cnt_q <= word_cnt_d;
      ovf_q      <= ovf_d;
      unique case (state_q)
        IDLE:    if (en) state_q <= RUN;
        RUN:     if (!en) state_q <= (beat_d == '0) ? IDLE : FINISH;
        FINISH: begin
          if (en)        state_q <= RUN;
          else if (wrap) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = (state_q != IDLE) | m_valid | inflight_q;
  assign ovf_sticky = ovf_q;
  assign word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_sram_drain_ctrl.sv
// Self-checking bench for sram_drain_ctrl: a queue-based upstream FIFO, a stream-level
// reference model, a vector table for flag/FSM behaviour and directed corner sequences.
module tb_sram_drain_ctrl;

  localparam int BITS  = 12;
  localparam int BL    = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n, en, fifo_ready, fifo_overflow, fifo_read;
  logic             m_valid, m_last, m_ready, ovf_clr, ovf_sticky, busy;
  logic [BITS-1:0]  fifo_data, m_data;
  logic [CNT_W-1:0] word_cnt;

  sram_drain_ctrl #(.BITS(BITS), .BURST_LEN(BL), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .fifo_ready    (fifo_ready),
    .fifo_overflow (fifo_overflow),
    .fifo_data     (fifo_data),
    .fifo_read     (fifo_read),
    .m_valid       (m_valid),
    .m_data        (m_data),
    .m_last        (m_last),
    .m_ready       (m_ready),
    .ovf_clr       (ovf_clr),
    .ovf_sticky    (ovf_sticky),
    .busy          (busy),
    .word_cnt      (word_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  int cyc     = 0;
  bit rd_prev = 1'b0;
  bit rst_prev = 1'b1;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rd_prev  <= fifo_read;
    rst_prev <= rst_n;
  end

  typedef struct {
    logic [BITS-1:0] d;
    int              avail;
  } ent_t;

  typedef struct {
    logic [BITS-1:0] d;
    bit              last;
    int              c;
  } pop_t;

  typedef struct {
    bit rst, en, ovf, clr;
    bit e_ovf, e_busy;
  } vec_t;

  ent_t            exp_q[$];
  pop_t            log_q[$];
  logic [BITS-1:0] fq[$];
  vec_t            vec[11];

  int              acc = 0;
  bit              model_valid = 1'b0;
  bit              ovf_m = 1'b0;
  bit              prev_en_ok = 1'b0;
  bit              prev_hold = 1'b0;
  logic [BITS-1:0] prev_data = '0;
  int              first_rd = -1;
  int              first_mv = -1;
  int              rd_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Upstream FIFO: a word read in one cycle appears on fifo_data during the next.
  task automatic fifo_update();
    if (rd_prev && fq.size() != 0) begin
      fifo_data = fq.pop_front();
      if (rst_prev) exp_q.push_back('{d: fifo_data, avail: cyc + 1});
    end
    if (!rst_prev) begin
      exp_q.delete();
      acc         = 0;
      model_valid = 1'b1;
    end
    fifo_ready = (fq.size() != 0);
  endtask

  // One clock: drive inputs after the falling edge, then compare against the model.
  task automatic step(input bit rst, input bit en_v, input bit mr, input bit ovf, input bit clr);
    bit exp_mv, pop;
    int beat;
    @(negedge clk);
    fifo_update();
    rst_n = rst; en = en_v; m_ready = mr; fifo_overflow = ovf; ovf_clr = clr;
    #1;
    if (fifo_read && rst) begin
      rd_seen++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (m_valid && first_mv < 0) first_mv = cyc;
    if (model_valid) begin
      beat   = acc % BL;
      exp_mv = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
      pop    = m_valid && m_ready && rst;
      check("m_valid", 32'(m_valid), 32'(exp_mv));
      if (exp_mv) begin
        check("m_data", 32'(m_data), 32'(exp_q[0].d));
        check("m_last", 32'(m_last), 32'(beat == BL - 1));
      end else begin
        check("m_last_idle", 32'(m_last), 32'(0));
      end
      check("word_cnt", 32'(word_cnt), 32'(acc % (1 << CNT_W)));
      check("ovf_sticky", 32'(ovf_sticky), 32'(ovf_m));
      if (prev_hold) begin
        check("hold_valid", 32'(m_valid), 32'(1));
        check("hold_data", 32'(m_data), 32'(prev_data));
      end
      if (fifo_read) begin
        check("read_when_ready", 32'(fifo_ready), 32'(1));
        check("read_credit", 32'(exp_q.size() - int'(pop) < 2), 32'(1));
        if (!en_v) check("read_wind_down", 32'((beat != 0) && (exp_q.size() < BL - beat)), 32'(1));
      end
      if (prev_en_ok && en_v && rst)
        check("read_rate", 32'(fifo_read), 32'(fifo_ready && (exp_q.size() - int'(pop) < 2)));
      if (pop && exp_q.size() > 0) begin
        log_q.push_back('{d: m_data, last: m_last, c: cyc});
        void'(exp_q.pop_front());
        acc++;
      end
    end
    if (!rst)     ovf_m = 1'b0;
    else if (ovf) ovf_m = 1'b1;
    else if (clr) ovf_m = 1'b0;
    prev_en_ok = en_v && rst;
    prev_hold  = rst && m_valid && !m_ready;
    prev_data  = m_data;
  endtask

  task automatic reset_all();
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    fq.delete();
    log_q.delete();
    first_rd = -1;
    first_mv = -1;
    rd_seen  = 0;
  endtask

  task automatic push_words(input int base, input int n);
    for (int i = 0; i < n; i++) fq.push_back(BITS'(base + i));
  endtask

  task automatic run_until(input string name, input int target, input bit en_v, input int budget);
    int k = 0;
    while (log_q.size() < target && k < budget) begin
      step(1'b1, en_v, 1'b1, 1'b0, 1'b0);
      k++;
    end
    check(name, 32'(log_q.size()), 32'(target));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n0;
    bit en_r;
    vec[0]  = '{0, 0, 0, 0, 0, 0};
    vec[1]  = '{1, 0, 1, 0, 1, 0};
    vec[2]  = '{1, 0, 0, 0, 1, 0};
    vec[3]  = '{1, 0, 0, 1, 0, 0};
    vec[4]  = '{1, 0, 1, 1, 1, 0};
    vec[5]  = '{1, 0, 0, 1, 0, 0};
    vec[6]  = '{1, 1, 0, 0, 0, 1};
    vec[7]  = '{1, 0, 0, 0, 0, 0};
    vec[8]  = '{1, 1, 1, 0, 1, 1};
    vec[9]  = '{0, 1, 0, 0, 0, 0};
    vec[10] = '{1, 0, 0, 0, 0, 0};

    rst_n = 1'b0; en = 1'b0; m_ready = 1'b0; fifo_overflow = 1'b0; ovf_clr = 1'b0;
    fifo_ready = 1'b0; fifo_data = '0;

    // Reset with the FIFO reporting data.
    push_words('h0A0, 3);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("rst_fifo_read_in", 32'(fifo_read), 32'(0));
    @(posedge clk); #1;
    check("rst_fifo_read", 32'(fifo_read), 32'(0));
    check("rst_m_valid", 32'(m_valid), 32'(0));
    check("rst_word_cnt", 32'(word_cnt), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));

    // Straight stream of two bursts.
    reset_all();
    push_words('h0E0, 8);
    run_until("stream_count", 8, 1'b1, 40);
    for (int i = 0; i < 8 && i < log_q.size(); i++) begin
      check("stream_data", 32'(log_q[i].d), 32'('h0E0 + i));
      check("stream_last", 32'(log_q[i].last), 32'(i % BL == BL - 1));
    end
    if (log_q.size() == 8) check("stream_rate", 32'(log_q[7].c - log_q[0].c), 32'(7));
    check("stream_latency", 32'(first_mv - first_rd), 32'(2));
    @(posedge clk); #1;
    check("stream_word_cnt", 32'(word_cnt), 32'(8));

    // Backpressure mid-stream.
    reset_all();
    push_words('h0E0, 16);
    repeat (4) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    n0 = rd_seen;
    repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("bp_reads_le2", 32'(rd_seen - n0 <= 2), 32'(1));
    run_until("bp_count", 16, 1'b1, 60);
    for (int i = 0; i < 16 && i < log_q.size(); i++)
      check("bp_data", 32'(log_q[i].d), 32'('h0E0 + i));

    // en dropped at beat 2: the burst is completed, then the block goes idle.
    reset_all();
    push_words('h0E0, 12);
    run_until("drop_pre", 2, 1'b1, 30);
    n0 = log_q.size();
    repeat (8) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("drop_words", 32'(log_q.size() - n0), 32'(2));
    check("drop_last", 32'(log_q[log_q.size()-1].last), 32'(1));
    check("drop_last_data", 32'(log_q[log_q.size()-1].d), 32'('h0E3));
    check("drop_busy", 32'(busy), 32'(0));

    // FIFO runs dry mid-burst, then refills.
    reset_all();
    push_words('h0E0, 6);
    repeat (14) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("dry_count", 32'(log_q.size()), 32'(6));
    check("dry_word_cnt", 32'(word_cnt), 32'(6));
    check("dry_m_valid", 32'(m_valid), 32'(0));
    check("dry_fifo_read", 32'(fifo_read), 32'(0));
    check("dry_busy", 32'(busy), 32'(1));
    push_words('h0E6, 2);
    run_until("refill_count", 8, 1'b1, 20);
    if (log_q.size() == 8) begin
      check("refill_e6_last", 32'(log_q[6].last), 32'(0));
      check("refill_e7_last", 32'(log_q[7].last), 32'(1));
      check("refill_e7_data", 32'(log_q[7].d), 32'('h0E7));
    end

    // Overflow flag and FSM idle/run transitions from the vector table.
    reset_all();
    for (int i = 0; i < 11; i++) begin
      step(vec[i].rst, vec[i].en, 1'b1, vec[i].ovf, vec[i].clr);
      @(posedge clk); #1;
      check($sformatf("vec%0d_ovf", i), 32'(ovf_sticky), 32'(vec[i].e_ovf));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vec[i].e_busy));
    end

    // Reset while busy: everything clears, nothing in flight reappears.
    push_words('h0C0, 10);
    repeat (4) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("pre_rst_busy", 32'(busy), 32'(1));
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("midrst_m_valid", 32'(m_valid), 32'(0));
    check("midrst_m_data", 32'(m_data), 32'(0));
    check("midrst_m_last", 32'(m_last), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_word_cnt", 32'(word_cnt), 32'(0));
    check("midrst_ovf", 32'(ovf_sticky), 32'(0));
    check("midrst_fifo_read", 32'(fifo_read), 32'(0));
    repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("postrst_busy", 32'(busy), 32'(0));

    // Randomised traffic against the stream model.
    reset_all();
    en_r = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) en_r = !en_r;
      if (fq.size() < 6 && $urandom_range(2) != 0) fq.push_back(BITS'($urandom));
      step($urandom_range(400) != 0, en_r, $urandom_range(9) < 7,
           $urandom_range(19) == 0, $urandom_range(9) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
